// File: rtl/aes_inv_subbytes_seq.sv
// rtl/aes_inv_subbytes_seq.sv - sequential composite-field InvSubBytes engine, LANES bytes per cycle
// Optional lane pipeline register after the GF(2^4) inversion: define INV_SBOX_PIPE_EN.
module aes_inv_subbytes_seq #(
  parameter int LANES = 4,
  parameter int GRP_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  localparam int NG = 16 / LANES;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NG - 1);
  // y^2 + y + LAMBDA is irreducible over GF(16) = GF(2)[w]/(w^4 + w + 1)
  localparam logic [3:0] LAMBDA = 4'hC;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // a^14 == a^-1 in GF(16), and maps 0 to 0
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] gf256c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  // Isomorphism columns are r^0..r^7 for a composite-field root r of x^8+x^4+x^3+x+1
  function automatic logic [63:0] find_iso();
    logic [63:0] cols;
    logic [71:0] pw;
    logic        found;
    cols  = '0;
    pw    = '0;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      if (!found) begin
        pw[7:0] = 8'h01;
        for (int i = 1; i < 9; i++)
          pw[8*i +: 8] = gf256c_mul(pw[8*(i-1) +: 8], 8'(c));
        if (pw[71:64] == (pw[39:32] ^ pw[31:24] ^ pw[15:8] ^ pw[7:0])) begin
          cols  = pw[63:0];
          found = 1'b1;
        end
      end
    end
    return cols;
  endfunction

  function automatic logic [63:0] invert_map(input logic [63:0] m);
    logic [63:0] cols;
    logic [7:0]  t;
    cols = '0;
    for (int a = 1; a < 256; a++) begin
      t = lin_map(m, 8'(a));
      for (int j = 0; j < 8; j++)
        if (t == 8'(1 << j)) cols[8*j +: 8] = 8'(a);
    end
    return cols;
  endfunction

  localparam logic [63:0] ISO     = find_iso();
  localparam logic [63:0] ISO_INV = invert_map(ISO);

  // Inverse affine, map into GF((2^4)^2), invert the norm; returns {ah, al, d^-1}
  function automatic logic [11:0] lane_front(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] c;
    logic [3:0] d;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    c = lin_map(ISO, a);
    d = gf16_mul(gf16_mul(c[7:4], c[7:4]), LAMBDA) ^ gf16_mul(c[7:4], c[3:0]) ^
        gf16_mul(c[3:0], c[3:0]);
    return {c, gf16_inv(d)};
  endfunction

  function automatic logic [7:0] lane_back(input logic [11:0] x);
    logic [3:0] bh;
    logic [3:0] bl;
    bh = gf16_mul(x[11:8], x[3:0]);
    bl = gf16_mul(x[11:8] ^ x[7:4], x[3:0]);
    return lin_map(ISO_INV, {bh, bl});
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [GRP_W-1:0]       cnt;
  logic [GRP_W-1:0]       wr_grp;
  logic [15:0][7:0]       work;
  logic [LANES-1:0][7:0]  lane_in;
  logic [LANES-1:0][7:0]  lane_res;
  logic [LANES-1:0][3:0]  rd_idx;
  logic [LANES-1:0][3:0]  wr_idx;

`ifdef INV_SBOX_PIPE_EN
  logic [LANES-1:0][11:0] lane_mid;
  logic [LANES-1:0][11:0] pipe_mid;
  logic                   pipe_vld;
  logic                   issue_done;
  logic [GRP_W-1:0]       pipe_grp;
  assign wr_grp = pipe_grp;
`else
  assign wr_grp = cnt;
`endif

  // Byte 0 lives in work[15], so group g lane l is work[15 - LANES*g - l]
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_idx[l]  = 4'(15 - LANES * int'(cnt) - l);
      wr_idx[l]  = 4'(15 - LANES * int'(wr_grp) - l);
      lane_in[l] = work[rd_idx[l]];
`ifdef INV_SBOX_PIPE_EN
      lane_mid[l] = lane_front(lane_in[l]);
      lane_res[l] = lane_back(pipe_mid[l]);
`else
      lane_res[l] = lane_back(lane_front(lane_in[l]));
`endif
    end
  end

  assign out_state = out_valid ? work : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef INV_SBOX_PIPE_EN
      pipe_mid   <= '0;
      pipe_vld   <= 1'b0;
      issue_done <= 1'b0;
      pipe_grp   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_state;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef INV_SBOX_PIPE_EN
            pipe_vld   <= 1'b0;
            issue_done <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef INV_SBOX_PIPE_EN
          pipe_mid <= lane_mid;
          pipe_grp <= cnt;
          pipe_vld <= !issue_done;
          if (!issue_done) begin
            if (cnt == LAST_GRP) issue_done <= 1'b1;
            else cnt <= cnt + 1'b1;
          end
          if (pipe_vld) begin
            for (int l = 0; l < LANES; l++) work[wr_idx[l]] <= lane_res[l];
            if (pipe_grp == LAST_GRP) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
`else
          for (int l = 0; l < LANES; l++) work[wr_idx[l]] <= lane_res[l];
          if (cnt == LAST_GRP) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
